// File: rtl/sensor_frame_check.sv
// sensor_frame_check: checks the emulated LVDS bus idle/frame protocol and frame content, recovers each frame's pattern word.
// Ports: clk, resetn (sync, active-low); lvds = bus under test; cycles_per_frame, idle_0/idle_1 and frame_header give the
// expected framing; clear_errors zeroes err_flags/err_count; frames_ok/frames_bad count closed frames; err_flags is the
// sticky bitmap (0 hdr, 1 ramp, 2 non-uniform data, 3 data/replica, 4 footer, 5 sync loss, 6 overflow, 7 bad config);
// PATTERN_* is a one-entry AXI-Stream master carrying the pattern of each clean frame.
// SENSOR_FRAME_CHECK_DATA_CMP_EN: when defined, repeated data cycles are compared against the captured byte.
module sensor_frame_check #(
  parameter int LVDS_WIDTH = 512,
  parameter int PATTERN_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [LVDS_WIDTH-1:0]    lvds,
  input  logic [31:0]              cycles_per_frame,
  input  logic [7:0]               idle_0,
  input  logic [7:0]               idle_1,
  input  logic [31:0]              frame_header,
  input  logic                     clear_errors,
  output logic [31:0]              frames_ok,
  output logic [31:0]              frames_bad,
  output logic [31:0]              err_count,
  output logic [7:0]               err_flags,
  output logic [PATTERN_WIDTH-1:0] PATTERN_TDATA,
  output logic                     PATTERN_TVALID,
  input  logic                     PATTERN_TREADY
);
  localparam int NB = LVDS_WIDTH / 8;
  localparam int PB = PATTERN_WIDTH / 8;
  typedef enum logic [2:0] {HUNT, EXP1, EXP0, HDR, DATA, FTR} state_t;
  state_t state, state_nx;
  logic [LVDS_WIDTH-1:0] bus, ramp;
  logic [PATTERN_WIDTH-1:0] pat;
  logic [31:0] n, n_nx, len, len_nx;
  logic [7:0] v [8];
  logic [7:0] vld, e, b0;
  logic [2:0] idx;
  logic fbad, uniform, start, close, cap, push, rep_err, frame_err;
  always_comb begin
    for (int k = 0; k < NB; k++) ramp[8*k+:8] = 8'(k);
    for (int k = 0; k < PB; k++) pat[8*k+:8] = v[7-k];
    b0 = bus[7:0];
    uniform = bus == {NB{b0}};
    idx = n[4:2];
    rep_err = 1'b0;
    // only bytes captured in this frame take part in the replica check
    for (int i = 0; i + PB < 8; i++) rep_err = rep_err | (vld[i] & vld[i+PB] & (v[i] != v[i+PB]));
    state_nx = state;
    n_nx = n + 32'd1;
    len_nx = len;
    e = '0;
    start = 1'b0;
    close = 1'b0;
    cap = 1'b0;
    case (state)
      HUNT: state_nx = uniform && b0 == idle_0 ? EXP1 : HUNT;
      EXP1: begin
        state_nx = uniform && b0 == idle_1 ? EXP0 : HUNT;
        e[5] = !(uniform && b0 == idle_1);
      end
      EXP0: begin
        // the matching cycle is itself header cycle n=0; idle_0 wins a tie with the header byte
        start = uniform && b0 != idle_0 && b0 == frame_header[7:0];
        state_nx = uniform && b0 == idle_0 ? EXP1 : HUNT;
        e[5] = !(uniform && (b0 == idle_0 || b0 == frame_header[7:0]));
      end
      HDR: begin
        if (n < 32'd4) e[0] = !uniform || b0 != frame_header[{n[1:0], 3'b000} +: 8];
        else if (n == 32'd11) e[1] = bus != ramp;
        else e[0] = bus != '0;
        if (n == 32'd15) state_nx = len > 32'd20 ? DATA : FTR;
      end
      DATA: begin
        e[2] = !uniform;
        cap = !vld[idx];
`ifdef SENSOR_FRAME_CHECK_DATA_CMP_EN
        e[3] = vld[idx] && b0 != v[idx];
`endif
        if (n == len - 32'd5) state_nx = FTR;
      end
      FTR: begin
        e[4] = bus != '0;
        if (n == len - 32'd1) begin
          close = 1'b1;
          e[3] = rep_err;
          state_nx = EXP0;
        end
      end
      default: state_nx = HUNT;
    endcase
    if (start) begin
      state_nx = HDR;
      n_nx = 32'd1;
      len_nx = cycles_per_frame < 32'd20 ? 32'd20 : cycles_per_frame;
      e[7] = cycles_per_frame < 32'd52 || cycles_per_frame[0];
    end
    // sync loss and overflow never mark a frame bad
    frame_err = start ? e[7] : fbad | e[7] | (|e[4:0]);
    push = close && !frame_err;
    e[6] = push && PATTERN_TVALID && !PATTERN_TREADY;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus <= '0;
      state <= HUNT;
      n <= '0;
      len <= '0;
      vld <= '0;
      fbad <= 1'b0;
      frames_ok <= '0;
      frames_bad <= '0;
      err_count <= '0;
      err_flags <= '0;
      PATTERN_TDATA <= '0;
      PATTERN_TVALID <= 1'b0;
    end else begin
      bus <= lvds;
      state <= state_nx;
      n <= n_nx;
      len <= len_nx;
      fbad <= frame_err;
      vld <= start ? '0 : cap ? vld | (8'd1 << idx) : vld;
      if (cap) v[idx] <= b0;
      frames_ok <= frames_ok + 32'(close && !frame_err);
      frames_bad <= frames_bad + 32'(close && frame_err);
      err_flags <= clear_errors ? '0 : err_flags | e;
      err_count <= clear_errors ? '0 : (|e && err_count != '1) ? err_count + 32'd1 : err_count;
      PATTERN_TDATA <= push ? pat : PATTERN_TDATA;
      PATTERN_TVALID <= push | (PATTERN_TVALID & !PATTERN_TREADY);
    end
  end
endmodule

// File: tb/tb_sensor_frame_check.sv
// tb_sensor_frame_check: directed and randomized frames against a frame-level reference model.
module tb_sensor_frame_check;
  localparam int W = 512;
  localparam int NB = W / 8;
  typedef logic [W-1:0] word_t;
  logic clk = 0, resetn = 0, clear_errors = 0, tready = 1;
  word_t lvds = '0;
  logic [31:0] cpf = 64;
  logic [7:0] idle_0 = 8'h55, idle_1 = 8'hAA;
  logic [31:0] hdr = 32'h12345678;
  logic [31:0] frames_ok, frames_bad, err_count, tdata;
  logic [7:0] err_flags;
  logic tvalid;
  int checks = 0, errors = 0;
  logic [31:0] m_ok = 0, m_bad = 0, m_cnt = 0, m_td = 0, pend_d = 0;
  logic [7:0] m_flags = 0;
  logic m_tv = 0, pend = 0;
  word_t fr[$];

  sensor_frame_check #(.LVDS_WIDTH(W), .PATTERN_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .lvds(lvds), .cycles_per_frame(cpf),
    .idle_0(idle_0), .idle_1(idle_1), .frame_header(hdr), .clear_errors(clear_errors),
    .frames_ok(frames_ok), .frames_bad(frames_bad), .err_count(err_count), .err_flags(err_flags),
    .PATTERN_TDATA(tdata), .PATTERN_TVALID(tvalid), .PATTERN_TREADY(tready)
  );

  always #5 clk = ~clk;

  function automatic word_t u(input logic [7:0] b);
    return {NB{b}};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ok"}, frames_ok, m_ok);
    check({tag, ".bad"}, frames_bad, m_bad);
    check({tag, ".flags"}, err_flags, m_flags);
    check({tag, ".cnt"}, err_count, m_cnt);
    check({tag, ".tv"}, tvalid, m_tv);
    if (m_tv) check({tag, ".td"}, tdata, m_td);
  endtask

  // one bus cycle; also tracks the expected output register
  task automatic send(input word_t w);
    logic drop;
    lvds = w;
    drop = tready && m_tv;
    @(posedge clk);
    #1;
    if (pend) begin
      m_tv = 1;
      m_td = pend_d;
      pend = 0;
    end else if (drop) m_tv = 0;
  endtask

  // generator view: v[j] carries pattern byte (7-j) mod 4, data cycle n carries v[(n/4) mod 8]
  function automatic void build(input logic [31:0] pat, input int len);
    word_t w;
    fr.delete();
    for (int n = 0; n < len; n++) begin
      w = '0;
      if (n < 4) w = u(hdr[8*n+:8]);
      else if (n == 11) for (int k = 0; k < NB; k++) w[8*k+:8] = 8'(k);
      else if (n >= 16 && n <= len - 5) w = u(pat[8*((7 - (n / 4) % 8) % 4)+:8]);
      fr.push_back(w);
    end
  endfunction

  // evaluate a whole transmitted frame against the protocol rules
  task automatic finish_model(input logic [31:0] c);
    int len, cnt, j;
    word_t ramp, w;
    logic [7:0] v [8];
    bit seen [8];
    logic [7:0] bits, all;
    len = c < 20 ? 20 : int'(c);
    cnt = 0;
    all = 0;
    for (int i = 0; i < 8; i++) begin
      seen[i] = 0;
      v[i] = 0;
    end
    for (int k = 0; k < NB; k++) ramp[8*k+:8] = 8'(k);
    for (int n = 0; n < len; n++) begin
      w = fr[n];
      j = (n / 4) % 8;
      bits = 0;
      if (n == 0) bits[7] = c < 52 || c[0];
      if (n < 4) bits[0] = w != u(hdr[8*n+:8]);
      else if (n == 11) bits[1] = w != ramp;
      else if (n < 16) bits[0] = w != '0;
      else if (n <= len - 5) begin
        bits[2] = w != u(w[7:0]);
        if (!seen[j]) begin
          seen[j] = 1;
          v[j] = w[7:0];
        end
`ifdef SENSOR_FRAME_CHECK_DATA_CMP_EN
        else bits[3] = w[7:0] != v[j];
`endif
      end else bits[4] = w != '0;
      if (n == len - 1)
        for (int i = 0; i < 4; i++) if (seen[i] && seen[i+4] && v[i] != v[i+4]) bits[3] = 1;
      all = all | bits;
      if (bits != 0) cnt++;
    end
    if (all == 0) begin
      m_ok++;
      pend = 1;
      pend_d = {v[4], v[5], v[6], v[7]};
      if (m_tv && !tready) begin
        all[6] = 1;
        cnt++;
      end
    end else m_bad++;
    m_flags = m_flags | all;
    m_cnt = m_cnt + cnt;
  endtask

  task automatic run_frame(input logic [31:0] pat, input logic [31:0] c, input int pos, input int kb,
                           input logic [7:0] xr, input bit z);
    word_t t;
    cpf = c;
    build(pat, c < 20 ? 20 : int'(c));
    if (pos >= 0) begin
      t = z ? '0 : fr[pos];
      t[8*kb+:8] = t[8*kb+:8] ^ xr;
      fr[pos] = t;
    end
    foreach (fr[i]) send(fr[i]);
    finish_model(c);
    check("tv_pre", tvalid, m_tv);
  endtask

  task automatic idle_aa(input bit clr);
    clear_errors = clr;
    send(u(8'hAA));
    clear_errors = 0;
    if (clr) begin
      m_flags = 0;
      m_cnt = 0;
    end
  endtask

  initial begin
    logic [31:0] p, c;
    int pos, kb, kind;
    logic [7:0] xr;
    bit z;
    repeat (3) send('0);
    check_all("reset");
    resetn = 1;
    send(u(8'h55));
    send(u(8'hAA));
    run_frame(32'hDEADBEEF, 64, -1, 0, 0, 0);
    send(u(8'h55));
    check_all("clean");
    check("clean.td", tdata, 32'hDEADBEEF);
    check("clean.flags", err_flags, 8'h00);
    idle_aa(0);
    check("clean.drop", tvalid, 1'b0);
    tready = 0;
    p = 0;
    for (int i = 0; i < 3; i++) begin
      p = $urandom;
      run_frame(p, 64, -1, 0, 0, 0);
    end
    send(u(8'h55));
    check_all("b2b");
    check("b2b.bit6", err_flags[6], 1'b1);
    check("b2b.td", tdata, p);
    tready = 1;
    idle_aa(1);
    check("b2b.drop", tvalid, 1'b0);
    check_all("clr");
    run_frame($urandom, 64, 11, 7, 8'h07, 0);
    send(u(8'h55));
    check_all("ramp");
    check("ramp.flags", err_flags, 8'h02);
    check("ramp.cnt", err_count, 32'd1);
    check("ramp.bad", frames_bad, 32'd1);
    check("ramp.tv", tvalid, 1'b0);
    idle_aa(1);
    run_frame($urandom, 64, 40, 5, 8'hFF, 0);
    send(u(8'h55));
    check_all("flip");
    check("flip.bit2", err_flags[2], 1'b1);
    idle_aa(1);
    run_frame($urandom | 32'h0000_0100, 64, 41, 0, 8'h00, 1);
    send(u(8'h55));
    check_all("zero");
`ifdef SENSOR_FRAME_CHECK_DATA_CMP_EN
    check("zero.bit3", err_flags[3], 1'b1);
`else
    check("zero.bit3", err_flags[3], 1'b0);
`endif
    idle_aa(1);
    send(u(8'h55));
    send(u(8'hAA));
    send(u(8'h33));
    m_flags[5] = 1;
    m_cnt++;
    send(u(8'h55));
    check_all("sync");
    check("sync.bit5", err_flags[5], 1'b1);
    send(u(8'hAA));
    run_frame($urandom, 64, -1, 0, 0, 0);
    send(u(8'h55));
    check_all("resync");
    idle_aa(0);
    run_frame($urandom, 40, -1, 0, 0, 0);
    send(u(8'h55));
    check_all("cfg");
    check("cfg.bit7", err_flags[7], 1'b1);
    idle_aa(0);
    cpf = 64;
    build($urandom, 64);
    for (int i = 0; i < 30; i++) send(fr[i]);
    resetn = 0;
    send('0);
    m_ok = 0;
    m_bad = 0;
    m_cnt = 0;
    m_flags = 0;
    m_tv = 0;
    pend = 0;
    check_all("midrst");
    check("midrst.td", tdata, 32'd0);
    resetn = 1;
    send(u(8'h55));
    send(u(8'hAA));
    for (int r = 0; r < 20; r++) begin
      p = $urandom;
      c = 52 + 2 * $urandom_range(0, 8);
      kind = $urandom_range(0, 5);
      pos = -1;
      kb = $urandom_range(0, NB - 1);
      xr = 8'($urandom_range(1, 255));
      z = 0;
      case (kind)
        1: begin
          pos = $urandom_range(1, 15);
          if (pos == 11) pos = 12;
        end
        2: pos = 11;
        3: begin
          pos = $urandom_range(16, int'(c) - 5);
          kb = $urandom_range(1, NB - 1);
        end
        4: begin
          pos = $urandom_range(16, int'(c) - 5);
          z = 1;
          xr = 0;
        end
        5: pos = $urandom_range(int'(c) - 4, int'(c) - 1);
        default: pos = -1;
      endcase
      run_frame(p, c, pos, kb, xr, z);
      send(u(8'h55));
      check_all("rnd");
      idle_aa(1'($urandom_range(0, 1)));
    end
    check_all("end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
